dtc_readout_sched: RTL and testbench

Per-event readout scheduler on the SRU side of the 40 DTC links. On each accepted trigger it grants the shared event-builder readout path to every enabled FEE link in ascending link order, one link at a time. Each grant lasts until that link reports its last word or a programmable timeout expires. It sits between the trigger/L1 logic and the 40 DTC receiver channels and flags per-link timeouts for the event header.

---
 rtl/dtc_sched_pkg.sv | 22 ++
 rtl/dtc_prio_enc.sv | 25 ++
 rtl/dtc_readout_sched.sv | 144 ++++++++++++++
 tb/tb_dtc_readout_sched.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dtc_sched_pkg.sv
// rtl/dtc_sched_pkg.sv - shared types and helpers for the DTC readout scheduler
package dtc_sched_pkg;

  localparam int NCH_DEF  = 40;
  localparam int IDXW_DEF = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_GRANT,
    ST_GAP,
    ST_DONE
  } state_e;

  function automatic logic [NCH_DEF-1:0] idx2onehot(input logic [IDXW_DEF-1:0] idx);
    logic [NCH_DEF-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/dtc_prio_enc.sv
// rtl/dtc_prio_enc.sv - lowest-set-bit priority encoder over the pending link mask
module dtc_prio_enc
  import dtc_sched_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic [NCH-1:0]  req_i,
  output logic [IDXW-1:0] idx_o,
  output logic            valid_o
);

  // Scanning downward lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx_o = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDXW'(i);
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/dtc_readout_sched.sv
// rtl/dtc_readout_sched.sv - per-event readout sweep granting each enabled DTC link in ascending order
module dtc_readout_sched
  import dtc_sched_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int IDXW = IDXW_DEF,
  parameter int TOW  = 16
) (
  input  logic            rdoclk_i,
  input  logic            reset_n_i,
  input  logic            evt_start_i,
  input  logic [NCH-1:0]  fee_flag_i,
  input  logic [TOW-1:0]  timeout_cfg_i,
  input  logic [NCH-1:0]  dtc_last_i,
  output logic [NCH-1:0]  grant_o,
  output logic [IDXW-1:0] grant_idx_o,
  output logic            busy_o,
  output logic            evt_done_o,
  output logic [NCH-1:0]  timeout_flag_o,
  output logic            evt_overlap_o
);

  state_e            state_q, state_d;
  logic [NCH-1:0]    pending_q, pending_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [TOW-1:0]    cnt_q, cnt_d;
  logic [NCH-1:0]    tflag_q, tflag_d;
  logic              overlap_q, overlap_d;
  logic [NCH-1:0]    grant_q, grant_d;
  logic [IDXW-1:0]   grant_idx_q, grant_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [IDXW-1:0]   enc_idx;
  logic              enc_valid;
  logic [NCH_DEF-1:0] enc_onehot;
  logic              timeout_hit;

  dtc_prio_enc #(
    .NCH  (NCH),
    .IDXW (IDXW)
  ) u_prio_enc (
    .req_i   (pending_q),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  assign enc_onehot  = idx2onehot(IDXW_DEF'(enc_idx));
  assign timeout_hit = (timeout_cfg_i != '0) && (cnt_q == timeout_cfg_i - TOW'(1));

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    tflag_d     = tflag_q;
    overlap_d   = overlap_q;
    grant_d     = '0;
    grant_idx_d = '0;

    if (evt_start_i && (state_q != ST_IDLE)) begin
      overlap_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (evt_start_i) begin
          pending_d = ~fee_flag_i;
          tflag_d   = '0;
          state_d   = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (enc_valid) begin
          idx_d       = enc_idx;
          cnt_d       = '0;
          grant_d     = enc_onehot[NCH-1:0];
          grant_idx_d = enc_idx;
          state_d     = ST_GRANT;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_GRANT: begin
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        cnt_d       = (&cnt_q) ? cnt_q : cnt_q + TOW'(1);
        // A last word arriving on the timeout cycle still counts as a clean finish.
        if (dtc_last_i[idx_q]) begin
          pending_d[idx_q] = 1'b0;
          grant_d          = '0;
          grant_idx_d      = '0;
          state_d          = ST_GAP;
        end else if (timeout_hit) begin
          pending_d[idx_q] = 1'b0;
          tflag_d[idx_q]   = 1'b1;
          grant_d          = '0;
          grant_idx_d      = '0;
          state_d          = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_SCAN;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge rdoclk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      pending_q   <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      tflag_q     <= '0;
      overlap_q   <= 1'b0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tflag_q     <= tflag_d;
      overlap_q   <= overlap_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign grant_o        = grant_q;
  assign grant_idx_o    = grant_idx_q;
  assign busy_o         = busy_q;
  assign evt_done_o     = done_q;
  assign timeout_flag_o = tflag_q;
  assign evt_overlap_o  = overlap_q;

endmodule

// File: tb/tb_dtc_readout_sched.sv
// tb/tb_dtc_readout_sched.sv - self-checking bench for dtc_readout_sched
module tb_dtc_readout_sched;

  localparam int NCH  = 40;
  localparam int IDXW = 6;
  localparam int TOW  = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            evt_start;
  logic [NCH-1:0]  fee_flag;
  logic [TOW-1:0]  timeout_cfg;
  logic [NCH-1:0]  dtc_last;
  logic [NCH-1:0]  grant;
  logic [IDXW-1:0] grant_idx;
  logic            busy;
  logic            evt_done;
  logic [NCH-1:0]  timeout_flag;
  logic            evt_overlap;

  int errors = 0;
  int checks = 0;

  int resp_dly [NCH];
  bit inj_overlap;
  bit inj_stray;

  int exp_idx[$];
  int exp_len[$];
  int obs_idx[$];
  int obs_len[$];
  int obs_start[$];
  int obs_fall[$];
  int done_cnt, done_cyc, busy_cnt, bad_oh, busy_after;

  logic [NCH-1:0] one_bit;

  always #5 clk = ~clk;

  dtc_readout_sched #(.NCH(NCH), .IDXW(IDXW), .TOW(TOW)) dut (
    .rdoclk_i       (clk),
    .reset_n_i      (reset_n),
    .evt_start_i    (evt_start),
    .fee_flag_i     (fee_flag),
    .timeout_cfg_i  (timeout_cfg),
    .dtc_last_i     (dtc_last),
    .grant_o        (grant),
    .grant_idx_o    (grant_idx),
    .busy_o         (busy),
    .evt_done_o     (evt_done),
    .timeout_flag_o (timeout_flag),
    .evt_overlap_o  (evt_overlap)
  );

  // Drives one event and records what the DUT does; cyc=k is the cycle after edge N+k-1.
  task automatic run_sweep(input logic [NCH-1:0] fee, input int budget);
    int cyc, glen, cur;
    obs_idx.delete(); obs_len.delete(); obs_start.delete(); obs_fall.delete();
    done_cnt = 0; done_cyc = -1; busy_cnt = 0; bad_oh = 0; busy_after = -1;
    glen = 0; cur = 0;
    @(negedge clk);
    fee_flag  = fee;
    evt_start = 1'b1;
    @(negedge clk);
    evt_start = 1'b0;
    cyc = 1;
    forever begin
      if (busy) busy_cnt++;
      if (evt_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = int'(busy);
      dtc_last = '0;
      if (grant != '0) begin
        if (glen == 0) begin
          cur = int'(grant_idx);
          obs_idx.push_back(cur);
          obs_start.push_back(cyc);
        end
        if (grant !== (one_bit << grant_idx)) bad_oh++;
        glen++;
        if (inj_stray) dtc_last = ~grant;
        if (glen == resp_dly[cur]) dtc_last[cur] = 1'b1;
      end else if (glen > 0) begin
        obs_len.push_back(glen);
        obs_fall.push_back(cyc);
        glen = 0;
      end
      evt_start = inj_overlap && (cyc == 3 || cyc == 10);
      if (done_cyc >= 0 && cyc >= done_cyc + 1) break;
      if (cyc >= budget) break;
      @(negedge clk);
      cyc++;
    end
    dtc_last  = '0;
    evt_start = 1'b0;
    checks++;
    if (done_cyc < 0) begin
      errors++;
      $display("FAIL sweep_budget: no evt_done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset;
    checks += 6;
    if (grant !== '0) begin errors++; $display("FAIL rst_grant: got %0h expected 0", grant); end
    if (grant_idx !== '0) begin errors++; $display("FAIL rst_grant_idx: got %0d expected 0", grant_idx); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    if (evt_done !== 1'b0) begin errors++; $display("FAIL rst_evt_done: got %b expected 0", evt_done); end
    if (timeout_flag !== '0) begin errors++; $display("FAIL rst_tflag: got %0h expected 0", timeout_flag); end
    if (evt_overlap !== 1'b0) begin errors++; $display("FAIL rst_overlap: got %b expected 0", evt_overlap); end
  endtask

  task automatic compare_grants(input string tag);
    int e, o;
    while (exp_idx.size() > 0) begin
      e = exp_idx.pop_front();
      checks++;
      if (obs_idx.size() == 0) begin
        errors++; $display("FAIL %s_idx: got none expected link %0d", tag, e);
      end else begin
        o = obs_idx.pop_front();
        if (o !== e) begin errors++; $display("FAIL %s_idx: got %0d expected %0d", tag, o, e); end
      end
    end
    checks++;
    if (obs_idx.size() != 0) begin
      errors++; $display("FAIL %s_extra: got %0d extra grants expected 0", tag, obs_idx.size());
    end
    while (exp_len.size() > 0) begin
      e = exp_len.pop_front();
      checks++;
      if (obs_len.size() == 0) begin
        errors++; $display("FAIL %s_len: got none expected %0d", tag, e);
      end else begin
        o = obs_len.pop_front();
        if (o !== e) begin errors++; $display("FAIL %s_len: got %0d expected %0d", tag, o, e); end
      end
    end
    checks++;
    if (bad_oh != 0) begin errors++; $display("FAIL %s_onehot: got %0d bad cycles expected 0", tag, bad_oh); end
  endtask

  task automatic test_full_sweep;
    timeout_cfg = '0;
    for (int k = 0; k < NCH; k++) begin
      resp_dly[k] = 4;
      exp_idx.push_back(k);
      exp_len.push_back(4);
    end
    run_sweep('0, 2000);
    checks += 4;
    if (done_cnt != 1) begin errors++; $display("FAIL full_done_cnt: got %0d expected 1", done_cnt); end
    if (timeout_flag !== '0) begin errors++; $display("FAIL full_tflag: got %0h expected 0", timeout_flag); end
    if (obs_fall.size() == 0 || done_cyc != obs_fall[$] + 2) begin
      errors++; $display("FAIL full_done_time: got cyc %0d expected last_fall+2", done_cyc);
    end
    if (busy_after != 0) begin errors++; $display("FAIL full_busy_after: got %0d expected 0", busy_after); end
    compare_grants("full");
  endtask

  task automatic test_timeout;
    logic [NCH-1:0] fee;
    fee = '1; fee[0] = 1'b0;
    timeout_cfg = 16'd10;
    resp_dly[0] = -1;
    exp_idx.push_back(0);
    exp_len.push_back(10);
    run_sweep(fee, 200);
    checks += 3;
    if (timeout_flag !== 40'h1) begin errors++; $display("FAIL to_tflag: got %0h expected 1", timeout_flag); end
    if (obs_fall.size() == 0 || done_cyc != obs_fall[0] + 2) begin
      errors++; $display("FAIL to_done_time: got cyc %0d expected fall+2", done_cyc);
    end
    if (done_cnt != 1) begin errors++; $display("FAIL to_done_cnt: got %0d expected 1", done_cnt); end
    compare_grants("to");
  endtask

  task automatic test_all_excluded;
    timeout_cfg = '0;
    run_sweep('1, 50);
    checks += 4;
    if (obs_idx.size() != 0) begin errors++; $display("FAIL excl_grants: got %0d expected 0", obs_idx.size()); end
    if (done_cyc != 2) begin errors++; $display("FAIL excl_done_time: got %0d expected 2", done_cyc); end
    if (busy_cnt != 2) begin errors++; $display("FAIL excl_busy_len: got %0d expected 2", busy_cnt); end
    if (timeout_flag !== '0) begin errors++; $display("FAIL excl_tflag: got %0h expected 0", timeout_flag); end
  endtask

  task automatic test_overlap;
    logic [NCH-1:0] fee;
    int en [4] = '{3, 7, 8, 20};
    fee = '1;
    timeout_cfg = '0;
    foreach (en[i]) begin
      fee[en[i]] = 1'b0;
      resp_dly[en[i]] = 2;
      exp_idx.push_back(en[i]);
      exp_len.push_back(2);
    end
    inj_overlap = 1'b1;
    inj_stray   = 1'b1;
    run_sweep(fee, 300);
    inj_overlap = 1'b0;
    inj_stray   = 1'b0;
    checks += 3;
    if (evt_overlap !== 1'b1) begin errors++; $display("FAIL ovl_flag: got %b expected 1", evt_overlap); end
    if (done_cnt != 1) begin errors++; $display("FAIL ovl_done_cnt: got %0d expected 1", done_cnt); end
    if (timeout_flag !== '0) begin errors++; $display("FAIL ovl_tflag: got %0h expected 0", timeout_flag); end
    compare_grants("ovl");
  endtask

  task automatic test_coincident;
    logic [NCH-1:0] fee;
    fee = '1; fee[5] = 1'b0; fee[6] = 1'b0;
    timeout_cfg = 16'd4;
    resp_dly[5] = 4;
    resp_dly[6] = 2;
    exp_idx.push_back(5); exp_len.push_back(4);
    exp_idx.push_back(6); exp_len.push_back(2);
    run_sweep(fee, 200);
    checks += 3;
    if (timeout_flag !== '0) begin errors++; $display("FAIL coin_tflag: got %0h expected 0", timeout_flag); end
    if (obs_start.size() < 2 || obs_fall.size() < 1 || obs_start[1] != obs_fall[0] + 2) begin
      errors++; $display("FAIL coin_next_grant: got start %0d expected fall+2", (obs_start.size() > 1) ? obs_start[1] : -1);
    end
    if (evt_overlap !== 1'b1) begin errors++; $display("FAIL coin_overlap_sticky: got %b expected 1", evt_overlap); end
    compare_grants("coin");
  endtask

  task automatic test_reset_mid;
    int cyc, dones;
    bit hit;
    timeout_cfg = '0;
    @(negedge clk);
    fee_flag  = '0;
    evt_start = 1'b1;
    @(negedge clk);
    evt_start = 1'b0;
    hit = 1'b0;
    for (cyc = 0; cyc < 400 && !hit; cyc++) begin
      dtc_last = '0;
      if (grant[12]) hit = 1'b1;
      else begin
        if (grant != '0) dtc_last = grant;
        @(negedge clk);
      end
    end
    dtc_last = '0;
    checks++;
    if (!hit) begin errors++; $display("FAIL rmid_reach12: got no grant[12] expected one"); end
    #2 reset_n = 1'b0;
    #1;
    test_reset;
    dones = 0;
    repeat (3) begin
      @(negedge clk);
      if (evt_done) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL rmid_no_done: got %0d expected 0", dones); end
    reset_n = 1'b1;
    for (int k = 0; k < NCH; k++) begin
      resp_dly[k] = 1;
      exp_idx.push_back(k);
      exp_len.push_back(1);
    end
    run_sweep('0, 1000);
    compare_grants("rmid");
  endtask

  initial begin
    one_bit     = 1;
    reset_n     = 1'b0;
    evt_start   = 1'b0;
    fee_flag    = '0;
    timeout_cfg = '0;
    dtc_last    = '0;
    inj_overlap = 1'b0;
    inj_stray   = 1'b0;
    foreach (resp_dly[k]) resp_dly[k] = -1;
    repeat (3) @(negedge clk);
    test_reset;
    reset_n = 1'b1;
    @(negedge clk);
    test_full_sweep;
    test_timeout;
    test_all_excluded;
    test_overlap;
    test_coincident;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
